// File: rtl/mix_column_seq.sv
// mix_column_seq: sequential AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock
// Ports: clk/rst_n (sync active-low); in_valid/in_ready/dataIn/bypass accept a state;
//        out_valid/out_ready/dataOut deliver the mixed (or bypassed) state; busy = not IDLE.
// Column c of a state sits at bits [127-32c : 96-32c], byte 0 in the column's MSB byte.
module mix_column_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] dataIn,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataOut,
    output logic         busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
        $error("mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, stateNext;
    logic [1:0]   counter, counterNext;
    logic [127:0] workReg, workNext, mixedState, outReg, outNext;
    logic         readyReg;
    logic [31:0]  colIn  [COLS_PER_CYCLE];
    logic [31:0]  colOut [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // One mix unit per lane; lane g works on column counter+g, whose LSB sits at (3-idx)*32.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gUnit
        logic [1:0] idx;
        assign idx       = counter + 2'(g);
        assign colIn[g]  = workReg[{~idx, 5'b0} +: 32];
        assign colOut[g] = mixColumn(colIn[g]);
    end

    // Column c belongs to the group starting at c - c%N and is produced by lane c%N.
    always_comb begin
        mixedState = workReg;
        for (int c = 0; c < 4; c++)
            if (counter == 2'(c - c % COLS_PER_CYCLE))
                mixedState[(3 - c) * 32 +: 32] = colOut[c % COLS_PER_CYCLE];
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        workNext    = workReg;
        outNext     = outReg;
        case (state)
            IDLE: if (in_valid && readyReg) begin
                workNext    = dataIn;
                counterNext = 2'd0;
                stateNext   = bypass ? DONE : BUSY;
                outNext     = bypass ? dataIn : outReg;
            end
            BUSY: begin
                workNext    = mixedState;
                counterNext = counter + 2'(COLS_PER_CYCLE);
                stateNext   = (counter == 2'(4 - COLS_PER_CYCLE)) ? DONE : BUSY;
                outNext     = (counter == 2'(4 - COLS_PER_CYCLE)) ? mixedState : outReg;
            end
            DONE: stateNext = out_ready ? IDLE : DONE;
            default: stateNext = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through the reset cycle and rises on the first edge after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            counter  <= 2'd0;
            workReg  <= '0;
            outReg   <= '0;
            readyReg <= 1'b0;
        end else begin
            state    <= stateNext;
            counter  <= counterNext;
            workReg  <= workNext;
            outReg   <= outNext;
            readyReg <= (stateNext == IDLE);
        end
    end

    assign in_ready  = readyReg;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dataOut   = outReg;
endmodule

// File: tb/tb_mix_column_seq.sv
// tb_mix_column_seq: scoreboard bench for mix_column_seq (main instance N=1, latency probes N=2 and N=4)
module tb_mix_column_seq;
    logic         clk = 0, rstN = 0, inValid = 0, auxValid = 0, bypass = 0, outReady = 1;
    logic [127:0] dataIn = '0;
    logic         rdy1, ov1, busy1, rdy2, ov2, busy2, rdy4, ov4, busy4;
    logic [127:0] do1, do2, do4;
    int           checks = 0, errors = 0, cyc = 0;
    logic [127:0] expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mix_column_seq #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(rdy1),
        .dataIn(dataIn), .bypass(bypass), .out_valid(ov1), .out_ready(outReady), .dataOut(do1), .busy(busy1));
    mix_column_seq #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst_n(rstN), .in_valid(auxValid), .in_ready(rdy2),
        .dataIn(dataIn), .bypass(bypass), .out_valid(ov2), .out_ready(1'b1), .dataOut(do2), .busy(busy2));
    mix_column_seq #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst_n(rstN), .in_valid(auxValid), .in_ready(rdy4),
        .dataIn(dataIn), .bypass(bypass), .out_valid(ov4), .out_ready(1'b1), .dataOut(do4), .busy(busy4));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] mixRef(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a[4];
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32 * c - 8 * k -: 8];
            for (int k = 0; k < 4; k++)
                r[127 - 32 * c - 8 * k -: 8] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k + 1) % 4]) ^ a[(k + 2) % 4] ^ a[(k + 3) % 4];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic sendOne(input logic [127:0] d, input logic byp, input logic [127:0] exp);
        int n = 0;
        while (!rdy1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("send_ready", 128'(rdy1), 128'd1);
        dataIn = d; bypass = byp; inValid = 1;
        expQ.push_back(exp);
        @(posedge clk); #1 inValid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("drain", 128'(expQ.size()), 128'd0);
    endtask

    always @(negedge clk)
        if (rstN && ov1 && outReady) begin
            if (expQ.size() == 0) chk("unexpected_out", 128'(ov1), 128'd0);
            else chk("sb_data", do1, expQ.pop_front());
        end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, stallExp;
        int lat1, lat2, lat4, n;
        int t[5];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(rdy1), 128'd0);
        chk("rst_out_valid", 128'(ov1), 128'd0);
        chk("rst_busy", 128'(busy1), 128'd0);
        chk("rst_dataOut", do1, 128'd0);
        rstN = 1;
        #1 chk("in_ready_before_edge", 128'(rdy1), 128'd0);
        @(posedge clk); #1;
        chk("in_ready_after_rst", 128'(rdy1), 128'd1);

        a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        b = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        auxValid = 1;
        sendOne(a, 0, b);
        auxValid = 0;
        lat1 = 0; lat2 = 0; lat4 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ov1 && lat1 == 0) lat1 = k;
            if (ov2 && lat2 == 0) begin lat2 = k; chk("cols2_data", do2, b); end
            if (ov4 && lat4 == 0) begin lat4 = k; chk("cols4_data", do4, b); end
        end
        @(posedge clk); #1;
        chk("lat_cols1", 128'(lat1), 128'd5);
        chk("lat_cols2", 128'(lat2), 128'd3);
        chk("lat_cols4", 128'(lat4), 128'd2);
        drain();

        sendOne({32'hd4bf5d30, 96'h0}, 0, {32'h046681e5, 96'h0});
        drain();

        a = rnd128();
        sendOne(a, 1, a);
        @(negedge clk);
        chk("byp_valid", 128'(ov1), 128'd1);
        chk("byp_busy", 128'(busy1), 128'd1);
        @(negedge clk);
        chk("byp_busy_drop", 128'(busy1), 128'd0);
        chk("byp_valid_drop", 128'(ov1), 128'd0);
        @(posedge clk); #1;

        outReady = 0;
        a = rnd128();
        stallExp = mixRef(a);
        sendOne(a, 0, stallExp);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin dataIn = ~a; inValid = 1; end
            if (k == 4) inValid = 0;
            @(negedge clk);
            chk("stall_valid", 128'(ov1), 128'd1);
            chk("stall_data", do1, stallExp);
            chk("stall_in_ready", 128'(rdy1), 128'd0);
            @(posedge clk); #1;
        end
        outReady = 1;
        @(posedge clk); #1;
        chk("release_idle", 128'(busy1), 128'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("stall_drained", 128'(expQ.size()), 128'd0);
        chk("stall_no_extra", 128'(busy1), 128'd0);

        a = rnd128();
        sendOne(a, 0, mixRef(a));
        @(posedge clk); @(posedge clk); #1;
        rstN = 0;
        void'(expQ.pop_back());
        @(posedge clk); #1 rstN = 1;
        chk("rst_mid_busy", 128'(busy1), 128'd0);
        chk("rst_mid_data", do1, 128'd0);
        chk("rst_mid_valid", 128'(ov1), 128'd0);
        chk("rst_mid_ready", 128'(rdy1), 128'd0);
        b = rnd128();
        sendOne(b, 0, mixRef(b));
        drain();

        inValid = 1; bypass = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            a = rnd128();
            dataIn = a;
            while (!rdy1 && n < 20) begin @(posedge clk); #1; n++; end
            t[i] = cyc;
            expQ.push_back(mixRef(a));
            @(posedge clk); #1;
        end
        inValid = 0;
        for (int i = 1; i < 5; i++) chk("b2b_period", 128'(t[i] - t[i - 1]), 128'd6);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 128'(busy1), 128'd0);
        chk("aux_idle", 128'({rdy2, busy2, rdy4, busy4}), 128'b1010);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
